// File: rtl/sig_monitor_pkg.sv
// Shared definitions for the signal-head monitor and the intersection controller:
// head colour encodings and latched fault codes.
package sig_pkg;

    typedef enum logic [1:0] {
        RED     = 2'b00,
        YELLOW  = 2'b01,
        GREEN   = 2'b10,
        ILLEGAL = 2'b11
    } colour_e;

    typedef enum logic [2:0] {
        FC_NONE         = 3'd0,
        FC_CONFLICT     = 3'd1,
        FC_BADCODE      = 3'd2,
        FC_SKIP_YELLOW  = 3'd3,
        FC_BAD_SEQ      = 3'd4,
        FC_SHORT_YELLOW = 3'd5,
        FC_SHORT_ALLRED = 3'd6,
        FC_RESERVED     = 3'd7
    } fault_code_e;

    // Bits needed to hold a saturating count of 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sig_monitor_if.sv
// Head-code inputs and fault-status outputs between the controller side (master)
// and the conflict monitor (slave).
interface sig_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    import sig_pkg::*;

    colour_e          hwy;
    colour_e          cntry;
    logic             fault_clr;
    logic             fault;
    logic [2:0]       fault_code;
    logic             flash;
    logic [CNT_W-1:0] viol_cnt;

    modport master (
        output hwy, cntry, fault_clr,
        input  fault, fault_code, flash, viol_cnt
    );

    modport slave (
        input  hwy, cntry, fault_clr,
        output fault, fault_code, flash, viol_cnt
    );

endinterface

// File: rtl/sig_monitor_head_chk.sv
// Per-head transition checks: compares the current head code against the one
// registered on the previous edge, together with that head's yellow run length.
module sig_head_chk
    import sig_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 3,
    parameter int unsigned YCNT_W     = 2
) (
    input  colour_e           cur_i,
    input  colour_e           prev_i,
    input  logic [YCNT_W-1:0] ycnt_i,
    output logic              skip_yellow_o,
    output logic              bad_seq_o,
    output logic              short_yellow_o,
    output logic              red_to_green_o
);

    always_comb begin
        skip_yellow_o  = (prev_i == GREEN) && (cur_i == RED);
        bad_seq_o      = ((prev_i == RED) && (cur_i == YELLOW)) ||
                         ((prev_i == YELLOW) && (cur_i == GREEN));
        short_yellow_o = (prev_i == YELLOW) && (cur_i == RED) &&
                         (32'(ycnt_i) < MIN_YELLOW);
        red_to_green_o = (prev_i == RED) && (cur_i == GREEN);
    end

endmodule

// File: rtl/sig_monitor.sv
// Conflict/sequence monitor for the highway and country signal heads; latches the
// first safety violation and commands fail-safe flashing red.
module sig_monitor
    import sig_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 3,
    parameter int unsigned MIN_ALLRED = 0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic          clock,
    input  logic          clear_n,
    sig_monitor_if.slave  bus
);

    localparam int unsigned YW = cnt_width(MIN_YELLOW);
    localparam int unsigned AW = cnt_width(MIN_ALLRED);

    colour_e          prev_hwy_q,   prev_hwy_d;
    colour_e          prev_cntry_q, prev_cntry_d;
    logic [YW-1:0]    ycnt_h_q,     ycnt_h_d;
    logic [YW-1:0]    ycnt_c_q,     ycnt_c_d;
    logic [AW-1:0]    allred_q,     allred_d;
    logic             primed_q,     primed_d;
    logic             fault_q,      fault_d;
    logic [2:0]       code_q,       code_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;

    logic skip_h, bad_seq_h, short_y_h, r2g_h;
    logic skip_c, bad_seq_c, short_y_c, r2g_c;

    sig_head_chk #(.MIN_YELLOW(MIN_YELLOW), .YCNT_W(YW)) u_chk_hwy (
        .cur_i          (bus.hwy),
        .prev_i         (prev_hwy_q),
        .ycnt_i         (ycnt_h_q),
        .skip_yellow_o  (skip_h),
        .bad_seq_o      (bad_seq_h),
        .short_yellow_o (short_y_h),
        .red_to_green_o (r2g_h)
    );

    sig_head_chk #(.MIN_YELLOW(MIN_YELLOW), .YCNT_W(YW)) u_chk_cntry (
        .cur_i          (bus.cntry),
        .prev_i         (prev_cntry_q),
        .ycnt_i         (ycnt_c_q),
        .skip_yellow_o  (skip_c),
        .bad_seq_o      (bad_seq_c),
        .short_yellow_o (short_y_c),
        .red_to_green_o (r2g_c)
    );

    logic        conflict, badcode, skip_yel, bad_seq, short_yel, short_ar, viol;
    fault_code_e vcode;

    always_comb begin
        conflict  = (bus.hwy != RED) && (bus.cntry != RED);
        badcode   = (bus.hwy == ILLEGAL) || (bus.cntry == ILLEGAL);
        // Transition and timing rules need a valid previous sample.
        skip_yel  = primed_q && (skip_h || skip_c);
        bad_seq   = primed_q && (bad_seq_h || bad_seq_c);
        short_yel = primed_q && (short_y_h || short_y_c);
        short_ar  = primed_q && (MIN_ALLRED > 0) && (r2g_h || r2g_c) &&
                    (32'(allred_q) < MIN_ALLRED);

        if (conflict)       vcode = FC_CONFLICT;
        else if (badcode)   vcode = FC_BADCODE;
        else if (skip_yel)  vcode = FC_SKIP_YELLOW;
        else if (bad_seq)   vcode = FC_BAD_SEQ;
        else if (short_yel) vcode = FC_SHORT_YELLOW;
        else if (short_ar)  vcode = FC_SHORT_ALLRED;
        else                vcode = FC_NONE;
        viol = (vcode != FC_NONE);
    end

    always_comb begin
        prev_hwy_d   = bus.hwy;
        prev_cntry_d = bus.cntry;
        primed_d     = 1'b1;

        ycnt_h_d = (bus.hwy != YELLOW) ? '0 :
                   (32'(ycnt_h_q) >= MIN_YELLOW) ? ycnt_h_q : ycnt_h_q + 1'b1;
        ycnt_c_d = (bus.cntry != YELLOW) ? '0 :
                   (32'(ycnt_c_q) >= MIN_YELLOW) ? ycnt_c_q : ycnt_c_q + 1'b1;
        allred_d = ((bus.hwy != RED) || (bus.cntry != RED)) ? '0 :
                   (32'(allred_q) >= MIN_ALLRED) ? allred_q : allred_q + 1'b1;

        // A violation coinciding with fault_clr reloads the code rather than clearing.
        fault_d = fault_q;
        code_d  = code_q;
        if (viol && (!fault_q || bus.fault_clr)) begin
            fault_d = 1'b1;
            code_d  = vcode;
        end else if (bus.fault_clr && !viol) begin
            fault_d = 1'b0;
            code_d  = '0;
        end

        cnt_d = (viol && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            prev_hwy_q   <= RED;
            prev_cntry_q <= RED;
            ycnt_h_q     <= '0;
            ycnt_c_q     <= '0;
            allred_q     <= '0;
            primed_q     <= 1'b0;
            fault_q      <= 1'b0;
            code_q       <= '0;
            cnt_q        <= '0;
        end else begin
            prev_hwy_q   <= prev_hwy_d;
            prev_cntry_q <= prev_cntry_d;
            ycnt_h_q     <= ycnt_h_d;
            ycnt_c_q     <= ycnt_c_d;
            allred_q     <= allred_d;
            primed_q     <= primed_d;
            fault_q      <= fault_d;
            code_q       <= code_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.fault      = fault_q;
    assign bus.flash      = fault_q;
    assign bus.fault_code = code_q;
    assign bus.viol_cnt   = cnt_q;

endmodule

// File: tb/tb_sig_monitor.sv
// Scoreboard bench for sig_monitor: three instances (default, MIN_YELLOW=2,
// MIN_ALLRED=2) driven by directed head-code vectors with hand-derived results.
module tb_sig_monitor;
    import sig_pkg::*;

    logic       clock = 1'b0;
    logic [2:0] rst_n = '0;

    always #5 clock = ~clock;

    sig_monitor_if #(.CNT_W(8)) bus_a ();
    sig_monitor_if #(.CNT_W(8)) bus_b ();
    sig_monitor_if #(.CNT_W(8)) bus_c ();

    sig_monitor #(.MIN_YELLOW(3), .MIN_ALLRED(0), .CNT_W(8)) dut_a (
        .clock(clock), .clear_n(rst_n[0]), .bus(bus_a));
    sig_monitor #(.MIN_YELLOW(2), .MIN_ALLRED(0), .CNT_W(8)) dut_b (
        .clock(clock), .clear_n(rst_n[1]), .bus(bus_b));
    sig_monitor #(.MIN_YELLOW(3), .MIN_ALLRED(2), .CNT_W(8)) dut_c (
        .clock(clock), .clear_n(rst_n[2]), .bus(bus_c));

    typedef struct {
        int unsigned sel;
        logic        f;
        logic [2:0]  code;
        logic [7:0]  cnt;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Drive one edge's inputs on the selected instance and queue the state expected after it.
    task automatic step(input int unsigned sel, input logic rn, input colour_e h,
                        input colour_e c, input logic clr, input logic ef,
                        input logic [2:0] ec, input logic [7:0] en, input string name);
        exp_t e;
        case (sel)
            0: begin bus_a.hwy = h; bus_a.cntry = c; bus_a.fault_clr = clr; end
            1: begin bus_b.hwy = h; bus_b.cntry = c; bus_b.fault_clr = clr; end
            default: begin bus_c.hwy = h; bus_c.cntry = c; bus_c.fault_clr = clr; end
        endcase
        rst_n[sel] = rn;
        e.sel = sel; e.f = ef; e.code = ec; e.cnt = en; e.name = name;
        sb.push_back(e);
        @(posedge clock);
        #5;
    endtask

    task automatic legal(input int unsigned sel, input int unsigned n, input colour_e h,
                         input colour_e c, input string name);
        for (int unsigned i = 0; i < n; i++) step(sel, 1'b1, h, c, 1'b0, 1'b0, 3'd0, 8'd0, name);
    endtask

    always @(posedge clock) begin : monitor
        exp_t       e;
        logic       af, afl;
        logic [2:0] ac;
        logic [7:0] avc;
        #2;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.sel)
                0: begin af = bus_a.fault; afl = bus_a.flash; ac = bus_a.fault_code; avc = bus_a.viol_cnt; end
                1: begin af = bus_b.fault; afl = bus_b.flash; ac = bus_b.fault_code; avc = bus_b.viol_cnt; end
                default: begin af = bus_c.fault; afl = bus_c.flash; ac = bus_c.fault_code; avc = bus_c.viol_cnt; end
            endcase
            n_checks++;
            if (af === e.f && afl === e.f && ac === e.code && avc === e.cnt)
                n_pass++;
            else
                $display("FAIL %s (dut %0d): got fault=%b flash=%b code=%0d cnt=%0d, want fault=%b flash=%b code=%0d cnt=%0d",
                         e.name, e.sel, af, afl, ac, avc, e.f, e.f, e.code, e.cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d entries pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_a.hwy = RED; bus_a.cntry = RED; bus_a.fault_clr = 1'b0;
        bus_b.hwy = RED; bus_b.cntry = RED; bus_b.fault_clr = 1'b0;
        bus_c.hwy = RED; bus_c.cntry = RED; bus_c.fault_clr = 1'b0;

        // Reset state on every instance.
        step(0, 1'b0, RED, RED, 1'b0, 1'b0, 3'd0, 8'd0, "reset_a");
        step(1, 1'b0, RED, RED, 1'b0, 1'b0, 3'd0, 8'd0, "reset_b");
        step(2, 1'b0, RED, RED, 1'b0, 1'b0, 3'd0, 8'd0, "reset_c");

        // Full legal controller cycle.
        legal(0, 5, GREEN,  RED,    "cycle_hwy_g");
        legal(0, 3, YELLOW, RED,    "cycle_hwy_y");
        legal(0, 2, RED,    RED,    "cycle_allred");
        legal(0, 4, RED,    GREEN,  "cycle_cntry_g");
        legal(0, 3, RED,    YELLOW, "cycle_cntry_y");
        legal(0, 1, GREEN,  RED,    "cycle_back");

        // Conflict, latch hold, fault_clr, and clear coincident with a new violation.
        step(0, 1'b1, GREEN, YELLOW, 1'b0, 1'b1, 3'd1, 8'd1, "conflict");
        step(0, 1'b1, GREEN, RED,    1'b0, 1'b1, 3'd1, 8'd2, "latch_hold");
        step(0, 1'b1, GREEN, RED,    1'b0, 1'b1, 3'd1, 8'd2, "quiet_hold");
        step(0, 1'b1, GREEN, RED,    1'b1, 1'b0, 3'd0, 8'd2, "clr_legal");
        step(0, 1'b1, RED,   RED,    1'b0, 1'b1, 3'd3, 8'd3, "skip_yellow");
        step(0, 1'b1, GREEN, GREEN,  1'b1, 1'b1, 3'd1, 8'd4, "clr_with_conflict");
        step(0, 1'b1, RED,   RED,    1'b0, 1'b1, 3'd1, 8'd5, "double_skip");
        step(0, 1'b1, RED,   RED,    1'b0, 1'b1, 3'd1, 8'd5, "steady");

        // Priority: badcode beats skip-yellow; later conflict keeps the code.
        step(0, 1'b0, RED,   RED,     1'b0, 1'b0, 3'd0, 8'd0, "reset_a2");
        step(0, 1'b1, GREEN, RED,     1'b0, 1'b0, 3'd0, 8'd0, "unprimed_g");
        step(0, 1'b1, RED,   ILLEGAL, 1'b0, 1'b1, 3'd2, 8'd1, "badcode_prio");
        step(0, 1'b1, GREEN, GREEN,   1'b0, 1'b1, 3'd2, 8'd2, "code_kept");
        step(0, 1'b1, RED,   RED,     1'b0, 1'b1, 3'd2, 8'd3, "skip_both");
        step(0, 1'b1, RED,   RED,     1'b0, 1'b1, 3'd2, 8'd3, "steady2");

        // Short yellow at MIN_YELLOW=3.
        step(0, 1'b0, RED, RED, 1'b0, 1'b0, 3'd0, 8'd0, "reset_a3");
        legal(0, 1, GREEN,  RED, "sy_g");
        legal(0, 2, YELLOW, RED, "sy_y");
        step(0, 1'b1, RED, RED, 1'b0, 1'b1, 3'd5, 8'd1, "short_yellow");

        // Same stimulus at MIN_YELLOW=2 is legal; a single yellow edge is not.
        legal(1, 1, GREEN,  RED, "sy2_g");
        legal(1, 2, YELLOW, RED, "sy2_y");
        legal(1, 1, RED,    RED, "sy2_r_ok");
        legal(1, 1, GREEN,  RED, "sy2_g2");
        legal(1, 1, YELLOW, RED, "sy2_y1");
        step(1, 1'b1, RED, RED, 1'b0, 1'b1, 3'd5, 8'd1, "short_yellow_1");

        // All-red clearance at MIN_ALLRED=2.
        legal(2, 2, RED, RED,    "ar_rr");
        legal(2, 1, RED, GREEN,  "ar_ok");
        legal(2, 3, RED, YELLOW, "ar_y");
        step(2, 1'b1, GREEN, RED, 1'b0, 1'b1, 3'd6, 8'd1, "short_allred_0");
        step(2, 1'b0, GREEN, RED, 1'b0, 1'b0, 3'd0, 8'd0, "reset_mid_fault");
        legal(2, 1, RED, GREEN,  "unprimed_r2g");
        legal(2, 1, RED, GREEN,  "primed_hold");
        legal(2, 3, RED, YELLOW, "ar_y2");
        legal(2, 1, RED, RED,    "ar_rr1");
        step(2, 1'b1, GREEN, RED, 1'b0, 1'b1, 3'd6, 8'd1, "short_allred_1");

        @(posedge clock);
        #5;
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
